cond_unit: RTL and testbench

//   Consumer of the ALU flag outputs (C_Flag, O_Flag, N_Flag, Z_Flag) in the execute/writeback stage.

---
 rtl/cond_unit.sv | 109 ++++++++++
 tb/tb_cond_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - NZCV status register, condition evaluation and gated one-entry output stage (option: COND_STATS_EN)
module cond_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cond,
  input  logic [1:0]       flag_write,
  input  logic             C_Flag,
  input  logic             O_Flag,
  input  logic             N_Flag,
  input  logic             Z_Flag,
  input  logic             reg_write_in,
  input  logic             mem_write_in,
  input  logic             pc_src_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             reg_write,
  output logic             mem_write,
  output logic             pc_src,
  output logic             cond_ok,
  output logic [3:0]       flags
`ifdef COND_STATS_EN
  ,
  output logic [CNT_W-1:0] squash_count
`endif
);

  logic flag_n, flag_z, flag_c, flag_v;
  logic pass;
  logic accept;

  assign flag_n = flags[3];
  assign flag_z = flags[2];
  assign flag_c = flags[1];
  assign flag_v = flags[0];

  // The output slot can take a new result when empty or when it is draining this cycle.
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // Evaluate the condition against the status register as it stands before this instruction.
  always_comb begin
    pass = 1'b1;
    case (cond)
      4'h0: pass = flag_z;
      4'h1: pass = ~flag_z;
      4'h2: pass = flag_c;
      4'h3: pass = ~flag_c;
      4'h4: pass = flag_n;
      4'h5: pass = ~flag_n;
      4'h6: pass = flag_v;
      4'h7: pass = ~flag_v;
      4'h8: pass = flag_c & ~flag_z;
      4'h9: pass = ~flag_c | flag_z;
      4'hA: pass = (flag_n == flag_v);
      4'hB: pass = (flag_n != flag_v);
      4'hC: pass = ~flag_z & (flag_n == flag_v);
      4'hD: pass = flag_z | (flag_n != flag_v);
      default: pass = 1'b1;  // AL, and the unused code F behaves as AL
    endcase
  end

  // Output stage and status register: capture on accept, hold while stalled, empty on drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      reg_write <= 1'b0;
      mem_write <= 1'b0;
      pc_src    <= 1'b0;
      cond_ok   <= 1'b0;
      flags     <= 4'b0000;
    end else if (accept) begin
      out_valid <= 1'b1;
      reg_write <= reg_write_in & pass;
      mem_write <= mem_write_in & pass;
      pc_src    <= pc_src_in & pass;
      cond_ok   <= pass;
      if (pass && flag_write[1]) begin
        flags[3] <= N_Flag;
        flags[2] <= Z_Flag;
      end
      if (pass && flag_write[0]) begin
        flags[1] <= C_Flag;
        flags[0] <= O_Flag;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef COND_STATS_EN
  // Count accepted instructions whose condition failed, sticking at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      squash_count <= '0;
    end else if (accept && !pass && (squash_count != {CNT_W{1'b1}})) begin
      squash_count <= squash_count + 1'b1;
    end
  end
`else
  // Keeps CNT_W referenced when the counter is not built.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - scoreboard bench for cond_unit
module tb_cond_unit;

  localparam int CNT_W = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] cond = 4'h0;
  logic [1:0] flag_write = 2'b00;
  logic       C_Flag = 1'b0, O_Flag = 1'b0, N_Flag = 1'b0, Z_Flag = 1'b0;
  logic       reg_write_in = 1'b0, mem_write_in = 1'b0, pc_src_in = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       reg_write, mem_write, pc_src, cond_ok;
  logic [3:0] flags;
`ifdef COND_STATS_EN
  logic [CNT_W-1:0] squash_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]       exp_q[$];
  logic [3:0]       model_flags = 4'b0000;
  logic [CNT_W-1:0] model_squash = '0;
  bit               rand_done;

  cond_unit #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .cond         (cond),
    .flag_write   (flag_write),
    .C_Flag       (C_Flag),
    .O_Flag       (O_Flag),
    .N_Flag       (N_Flag),
    .Z_Flag       (Z_Flag),
    .reg_write_in (reg_write_in),
    .mem_write_in (mem_write_in),
    .pc_src_in    (pc_src_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .reg_write    (reg_write),
    .mem_write    (mem_write),
    .pc_src       (pc_src),
    .cond_ok      (cond_ok),
    .flags        (flags)
`ifdef COND_STATS_EN
    ,
    .squash_count (squash_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural reference: condition table written from the N/Z/C/V definitions.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n ~^ v;
      4'hB: return n ^ v;
      4'hC: return !z && (n ~^ v);
      4'hD: return z || (n ^ v);
      default: return 1'b1;
    endcase
  endfunction

  // Scoreboard: compare the result leaving this cycle, then record the one entering.
  always @(negedge clk) begin
    logic ok;
    if (reset) begin
      exp_q.delete();
      model_flags  = 4'b0000;
      model_squash = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 1, 0);
        else check("out", {reg_write, mem_write, pc_src, cond_ok, flags}, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        ok = ref_pass(cond, model_flags);
        if (ok && flag_write[1]) model_flags[3:2] = {N_Flag, Z_Flag};
        if (ok && flag_write[0]) model_flags[1:0] = {C_Flag, O_Flag};
        if (!ok && model_squash != {CNT_W{1'b1}}) model_squash = model_squash + 1'b1;
        exp_q.push_back({reg_write_in & ok, mem_write_in & ok, pc_src_in & ok, ok, model_flags});
      end
    end
  end

  // Present one instruction and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] nzco,
                      input logic [2:0] we);
    bit taken = 0;
    cond = c;
    flag_write = fw;
    {N_Flag, Z_Flag, C_Flag, O_Flag} = nzco;
    {reg_write_in, mem_write_in, pc_src_in} = we;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !taken; i++) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk);
      #1;
    end
    if (!taken) check("accept_timeout", 0, 1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Wait for every queued result to leave the output stage.
  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] snap;
    logic [3:0] snap_flags;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_flags", flags, 4'b0000);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;

    // Reset arriving while a result is held in the output stage.
    out_ready = 1'b0;
    send(4'hE, 2'b11, 4'b1111, 3'b111);
    idle();
    check("pre_rst_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1 check("async_rst_valid", out_valid, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    check("rst1_out_valid", out_valid, 0);
    check("rst1_flags", flags, 4'b0000);
    check("rst1_in_ready", in_ready, 1);
    reset = 1'b0;
    out_ready = 1'b1;

    // AL with full flag write, then EQ branch on the new Z.
    send(4'hE, 2'b11, 4'b0110, 3'b100);
    idle();
    @(negedge clk);
    check("t2_valid", out_valid, 1);
    check("t2_reg_write", reg_write, 1);
    check("t2_flags", flags, 4'b0110);
    @(posedge clk); #1;
    send(4'h0, 2'b00, 4'b0000, 3'b001);
    idle();
    @(negedge clk);
    check("t2_pc_src", pc_src, 1);
    drain();

    // NE fails on Z=1: no write, flags untouched.
    send(4'h1, 2'b11, 4'b1111, 3'b010);
    idle();
    @(negedge clk);
    check("t3_mem_write", mem_write, 0);
    check("t3_cond_ok", cond_ok, 0);
    check("t3_flags", flags, 4'b0110);
`ifdef COND_STATS_EN
    check("t3_squash", squash_count, 1);
`endif
    drain();

    // N=1 V=0: GE fails, LT passes and writes only C,V.
    @(posedge clk); #1;
    send(4'hE, 2'b10, 4'b1000, 3'b000);
    send(4'hA, 2'b00, 4'b0000, 3'b000);
    idle();
    @(negedge clk);
    check("t4_ge_ok", cond_ok, 0);
    @(posedge clk); #1;
    send(4'hB, 2'b01, 4'b1101, 3'b000);
    idle();
    @(negedge clk);
    check("t4_lt_ok", cond_ok, 1);
    check("t4_flags", flags, 4'b1001);
    drain();

    // Stall: result held, new input refused for 3 cycles, then drain and accept together.
    @(posedge clk); #1;
    send(4'hE, 2'b11, 4'b0011, 3'b101);
    out_ready = 1'b0;
    cond = 4'hE; flag_write = 2'b11; {N_Flag, Z_Flag, C_Flag, O_Flag} = 4'b1100;
    {reg_write_in, mem_write_in, pc_src_in} = 3'b010;
    in_valid = 1'b1;
    @(negedge clk);
    snap = {reg_write, mem_write, pc_src, cond_ok, flags};
    snap_flags = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_valid", out_valid, 1);
      check("stall_hold", {reg_write, mem_write, pc_src, cond_ok, flags}, snap);
      check("stall_flags", flags, snap_flags);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("unstall_in_ready", in_ready, 1);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("unstall_flags", flags, 4'b1100);
    drain();

    // Exhaustive: every condition against every flag state.
    @(posedge clk); #1;
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        send(4'hE, 2'b11, f[3:0], 3'b000);
        send(c[3:0], 2'b00, 4'b0000, 3'b111);
      end
    end
    idle();
    drain();

    // Random stream with random backpressure.
    rand_done = 0;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
               3'($urandom_range(0, 7)));
          if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk); #1;
          end
        end
        idle();
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("final_flags", flags, model_flags);
`ifdef COND_STATS_EN
    check("final_squash", squash_count, model_squash);
`endif
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
